// File: rtl/axi_sram_responder_if.sv
// rtl/axi_sram_responder_if.sv - AXI bus bundle between the CPU master port and the SRAM responder
interface axi_sram_responder_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - single-transaction AXI subordinate over a single-port word RAM
module axi_sram_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_sram_responder_if.slave  bus
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WRESP  = 3'd2;
    localparam logic [2:0] S_RFETCH = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        prio_rd_q, prio_rd_d;
    logic [31:0] rdata_q;

    logic [31:0] mem [MEM_WORDS];

    logic        grant_ar, grant_aw;
    logic [31:0] offset;
    logic        in_range;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]  sz_eff;
    logic [31:0] step_bytes, wrap_mask, incr_addr, next_addr;
    logic        last_beat;

    assign grant_ar = (state_q == S_IDLE) && bus.arvalid && (!bus.awvalid || prio_rd_q);
    assign grant_aw = (state_q == S_IDLE) && bus.awvalid && !grant_ar;

    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    // Oversized transfers step a full word; WRAP keeps the high bits and wraps the low ones.
    assign sz_eff     = (size_q > 3'd2) ? 2'd2 : size_q[1:0];
    assign step_bytes = 32'd1 << sz_eff;
    assign wrap_mask  = (({28'd0, len_q} + 32'd1) << sz_eff) - 32'd1;
    assign incr_addr  = addr_q + step_bytes;
    assign last_beat  = (cnt_q == len_q);

    always_comb begin
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        prio_rd_d = prio_rd_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ar) begin
                    id_d    = bus.arid;
                    addr_d  = bus.araddr;
                    len_d   = bus.arlen;
                    size_d  = bus.arsize;
                    burst_d = bus.arburst;
                    cnt_d   = 4'd0;
                    err_d   = (bus.arburst == 2'b11) || (bus.arsize > 3'd2);
                    state_d = S_RFETCH;
                    if (bus.awvalid) prio_rd_d = ~prio_rd_q;
                end else if (grant_aw) begin
                    id_d    = bus.awid;
                    addr_d  = bus.awaddr;
                    len_d   = bus.awlen;
                    size_d  = bus.awsize;
                    burst_d = bus.awburst;
                    cnt_d   = 4'd0;
                    err_d   = (bus.awburst == 2'b11) || (bus.awsize > 3'd2);
                    state_d = S_WRITE;
                    if (bus.arvalid) prio_rd_d = ~prio_rd_q;
                end
            end
            S_WRITE: begin
                if (bus.wvalid) begin
                    if (!in_range || (bus.wlast != last_beat)) err_d = 1'b1;
                    addr_d = next_addr;
                    if (last_beat) state_d = S_WRESP;
                    else           cnt_d   = cnt_q + 4'd1;
                end
            end
            S_WRESP: begin
                if (bus.bready) state_d = S_IDLE;
            end
            S_RFETCH: begin
                if (!in_range) err_d = 1'b1;
                state_d = S_RDATA;
            end
            S_RDATA: begin
                if (bus.rready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_RFETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            id_q      <= 4'd0;
            addr_q    <= 32'd0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            prio_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            prio_rd_q <= prio_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_WRITE) && bus.wvalid && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // Read data is captured only in RFETCH, so it holds steady through R backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (state_q == S_RFETCH) begin
            rdata_q <= in_range ? mem[word_idx] : 32'd0;
        end
    end

    assign bus.awready = grant_aw;
    assign bus.arready = grant_ar;
    assign bus.wready  = (state_q == S_WRITE);
    assign bus.bvalid  = (state_q == S_WRESP);
    assign bus.bid     = id_q;
    assign bus.bresp   = {err_q, 1'b0};
    assign bus.rvalid  = (state_q == S_RDATA);
    assign bus.rid     = id_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = {err_q, 1'b0};
    assign bus.rlast   = (state_q == S_RDATA) && last_beat;
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - scoreboard bench for axi_sram_responder against a burst-level memory model
module tb_axi_sram_responder;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MEM_BYTES = 32'd4096;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;
    typedef logic [31:0] w16_t [16];
    typedef logic [3:0]  s16_t [16];

    logic clk = 1'b0;
    logic rst = 1'b1;
    axi_sram_responder_if bus();

    axi_sram_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial forever #5 clk = ~clk;

    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    int          errors = 0;
    int          checks = 0;
    int          r_pops = 0;
    logic [31:0] ref_mem [MEM_WORDS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [31:0] nb, cont, base;
        nb = 32'd1 << ((size > 2) ? 2 : size);
        case (burst)
            0: return start;
            2: begin
                cont = (len + 1) * nb;
                base = start - (start % cont);
                return base + (((start - base) + i * nb) % cont);
            end
            default: return start + i * nb;
        endcase
    endfunction

    function automatic bit is_last(input int i, input int len, input int bad_last);
        return (i == len) ^ (i == bad_last);
    endfunction

    task automatic model_write(input int id, input logic [31:0] addr, input int len, input int size,
                               input int burst, input w16_t data, input s16_t strb, input int bad_last);
        bit err;
        logic [31:0] a;
        bexp_t e;
        err = (burst == 3) || (size > 2);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (i == bad_last) err = 1;
            if (a < MEM_BYTES) begin
                for (int b = 0; b < 4; b++)
                    if (strb[i][b]) ref_mem[a >> 2][8*b +: 8] = data[i][8*b +: 8];
            end else begin
                err = 1;
            end
        end
        e.id = 4'(id);
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
    endtask

    task automatic model_read(input int id, input logic [31:0] addr, input int len,
                              input int size, input int burst);
        bit err;
        logic [31:0] a;
        rbeat_t e;
        err = (burst == 3) || (size > 2);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (a >= MEM_BYTES) err = 1;
            e.id   = 4'(id);
            e.data = (a < MEM_BYTES) ? ref_mem[a >> 2] : 32'd0;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_r.push_back(e);
        end
    endtask

    // Free-running random backpressure on the response channels.
    initial forever begin
        bus.rready = ($urandom_range(0, 3) != 0);
        bus.bready = ($urandom_range(0, 2) != 0);
        @(posedge clk);
        #1;
    end

    logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [3:0]  prev_id = 4'd0;
    logic [1:0]  prev_resp = 2'd0;
    rbeat_t      mr;
    bexp_t       mb;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 32'd1, 32'd0);
                end else begin
                    mb = exp_b.pop_front();
                    chk("bid", 32'(bus.bid), 32'(mb.id));
                    chk("bresp", 32'(bus.bresp), 32'(mb.resp));
                end
            end
            if (prev_rv && !prev_rr) begin
                chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
                chk("r_hold_data", bus.rdata, prev_data);
                chk("r_hold_meta", {25'd0, bus.rid, bus.rresp, bus.rlast},
                    {25'd0, prev_id, prev_resp, prev_last});
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 32'd1, 32'd0);
                end else begin
                    mr = exp_r.pop_front();
                    chk("rid", 32'(bus.rid), 32'(mr.id));
                    chk("rdata", bus.rdata, mr.data);
                    chk("rresp", 32'(bus.rresp), 32'(mr.resp));
                    chk("rlast", 32'(bus.rlast), 32'(mr.last));
                    r_pops++;
                end
            end
            prev_rv = bus.rvalid;
            prev_rr = bus.rready;
        end else begin
            prev_rv = 1'b0;
            prev_rr = 1'b0;
        end
        prev_data = bus.rdata;
        prev_id   = bus.rid;
        prev_resp = bus.rresp;
        prev_last = bus.rlast;
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("idle_timeout", 32'd1, 32'd0);
            exp_r.delete();
            exp_b.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input int id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
        int n = 0;
        bus.awid = 4'(id); bus.awaddr = addr; bus.awlen = 4'(len);
        bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.awready && n < 200);
        if (!bus.awready) chk("aw_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
    endtask

    task automatic drive_ar(input int id, input logic [31:0] addr, input int len,
                            input int size, input int burst);
        int n = 0;
        bus.arid = 4'(id); bus.araddr = addr; bus.arlen = 4'(len);
        bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 200);
        if (!bus.arready) chk("ar_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
    endtask

    // Called right after an AW handshake: first wready must already be up.
    task automatic w_phase(input w16_t data, input s16_t strb, input int len, input int bad_last,
                           input bit tchk);
        int n;
        for (int i = 0; i <= len; i++) begin
            bus.wdata = data[i]; bus.wstrb = strb[i];
            bus.wlast = is_last(i, len, bad_last); bus.wvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                if (tchk && i == 0 && n == 0) chk("wready_latency", 32'(bus.wready), 32'd1);
                n++;
            end while (!bus.wready && n < 200);
            if (!bus.wready) chk("w_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1 bus.wvalid = 1'b0;
            if (i == len) begin
                @(negedge clk);
                if (tchk) chk("bvalid_latency", 32'(bus.bvalid), 32'd1);
            end else if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_write(input int id, input logic [31:0] addr, input int len, input int size,
                            input int burst, input w16_t data, input s16_t strb,
                            input int bad_last, input bit tchk);
        model_write(id, addr, len, size, burst, data, strb, bad_last);
        drive_aw(id, addr, len, size, burst);
        w_phase(data, strb, len, bad_last, tchk);
        wait_idle();
    endtask

    task automatic do_read(input int id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit tchk);
        model_read(id, addr, len, size, burst);
        drive_ar(id, addr, len, size, burst);
        if (tchk) begin
            @(negedge clk);
            chk("rvalid_n1", 32'(bus.rvalid), 32'd0);
            @(negedge clk);
            chk("rvalid_n2", 32'(bus.rvalid), 32'd1);
        end
        wait_idle();
    endtask

    w16_t d;
    s16_t s;
    int   len, size, burst, bad;
    logic [31:0] addr;

    initial begin
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        for (int i = 0; i < 16; i++) begin d[i] = 0; s[i] = 4'hF; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, bus.awready, bus.arready}, 32'd0);
        chk("rst_valid", {28'd0, bus.wready, bus.bvalid, bus.rvalid, bus.rlast}, 32'd0);
        chk("rst_meta", {20'd0, bus.bid, bus.bresp, bus.rid, bus.rresp}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Arbitration: both requests together, read wins first, then write.
        model_read(1, 32'h2000, 0, 2, 1);
        bus.arid = 4'd1; bus.araddr = 32'h2000; bus.arlen = 0; bus.arsize = 2; bus.arburst = 1;
        bus.awid = 4'd2; bus.awaddr = 32'h1000; bus.awlen = 0; bus.awsize = 2; bus.awburst = 1;
        bus.arvalid = 1; bus.awvalid = 1;
        @(negedge clk);
        chk("prio1_grant", {30'd0, bus.arready, bus.awready}, 32'd2);
        @(posedge clk);
        #1 bus.arvalid = 0; bus.awvalid = 0;
        wait_idle();
        d[0] = 32'h1234_5678;
        model_write(2, 32'h1000, 0, 2, 1, d, s, -1);
        bus.arvalid = 1; bus.awvalid = 1;
        @(negedge clk);
        chk("prio2_grant", {30'd0, bus.arready, bus.awready}, 32'd1);
        @(posedge clk);
        #1 bus.arvalid = 0; bus.awvalid = 0;
        w_phase(d, s, 0, -1, 1'b1);
        wait_idle();

        for (int blk = 0; blk < 64; blk++) begin
            for (int j = 0; j < 16; j++) d[j] = 32'(blk * 16 + j);
            do_write(0, 32'(blk * 64), 15, 2, 1, d, s, -1, 1'b0);
        end

        d[0] = 32'hDEAD_BEEF;
        do_write(3, 32'h10, 0, 2, 1, d, s, -1, 1'b1);
        do_read(4, 32'h10, 0, 2, 1, 1'b1);
        for (int j = 0; j < 4; j++) d[j] = 32'(j + 1);
        do_write(5, 32'h100, 3, 2, 1, d, s, -1, 1'b1);
        do_read(6, 32'h100, 3, 2, 1, 1'b0);
        for (int j = 0; j < 4; j++) d[j] = 32'(j);
        do_write(7, 32'h100, 3, 2, 1, d, s, -1, 1'b0);
        do_read(8, 32'h108, 3, 2, 2, 1'b0);
        d[0] = 32'hAABB_CCDD; s[0] = 4'b0101;
        do_write(9, 32'h0, 0, 2, 1, d, s, -1, 1'b0);
        s[0] = 4'hF;
        do_read(10, 32'h0, 0, 2, 1, 1'b0);
        d[0] = 32'hFFFF_FFFF;
        do_write(11, 32'h1000, 0, 2, 1, d, s, -1, 1'b0);
        do_read(12, 32'h1000, 0, 2, 1, 1'b0);
        do_read(13, 32'h0, 0, 2, 1, 1'b0);

        for (int t = 0; t < 150; t++) begin
            burst = $urandom_range(0, 19);
            burst = (burst < 2) ? 0 : (burst < 14) ? 1 : (burst < 19) ? 2 : 3;
            size  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 2;
            if (burst == 2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = 32'($urandom_range(0, 32'h10FF)) & ~32'h3;
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < 16; j++) begin
                    d[j] = $urandom;
                    s[j] = 4'($urandom_range(0, 15));
                end
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                do_write($urandom_range(0, 15), addr, len, size, burst, d, s, bad, 1'b1);
            end else begin
                do_read($urandom_range(0, 15), addr, len, size, burst, 1'b1);
            end
        end

        // Reset in the middle of a long read burst.
        begin
            int start_pops, n;
            model_read(14, 32'h40, 15, 2, 1);
            start_pops = r_pops;
            drive_ar(14, 32'h40, 15, 2, 1);
            n = 0;
            while (r_pops < start_pops + 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("midburst_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1 rst = 1'b1;
            exp_r.delete();
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid_rvalid", {31'd0, bus.rvalid}, 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            do_read(15, 32'h44, 1, 2, 1, 1'b1);
        end

        chk("leftover_r", 32'(exp_r.size()), 32'd0);
        chk("leftover_b", 32'(exp_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
